// File: rtl/conv_pkg.sv
// Shared constants and types for the conv-output capture / flatten path.
package conv_pkg;

    localparam int CO_DEF      = 3;
    localparam int BW_DEF      = 32;
    localparam int FM_SIZE_DEF = 4;
    localparam int DEPTH_DEF   = FM_SIZE_DEF * FM_SIZE_DEF;
    localparam int TOTAL_DEF   = CO_DEF * DEPTH_DEF;

    // Counter width that never collapses to zero bits for degenerate sizes
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int POS_W_DEF  = clog2_min1(DEPTH_DEF);
    localparam int LANE_W_DEF = clog2_min1(CO_DEF);
    localparam int IDX_W_DEF  = clog2_min1(TOTAL_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pool_buf_mem.sv
// CO-lane frame buffer: full-width write per position, registered single-lane read.
module pool_buf_mem #(
    parameter int CO    = 3,
    parameter int BW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int LW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [CO*BW-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic [LW-1:0]    rd_lane_i,
    output logic [BW-1:0]    rd_data_o
);

    logic [CO*BW-1:0] mem_q [DEPTH];
    logic [BW-1:0]    rd_data_q;

    // Storage array: no reset, contents are only meaningful after a fill
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its value until the next read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i][rd_lane_i*BW +: BW];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pool_flatten_buf.sv
// Captures a CO-channel pooled frame and replays it as a flattened valid/ready stream.
// Build option POOLBUF_HWC_ORDER_EN selects position-major drain order.
module pool_flatten_buf
    import conv_pkg::*;
#(
    parameter int CO      = CO_DEF,
    parameter int BW      = BW_DEF,
    parameter int FM_SIZE = FM_SIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CO*BW-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_end,
    output logic [BW-1:0]    o_data,
    output logic             o_valid,
    output logic             o_last,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_err
);

    localparam int DEPTH  = FM_SIZE * FM_SIZE;
    localparam int TOTAL  = CO * DEPTH;
    localparam int POS_W  = clog2_min1(DEPTH);
    localparam int LANE_W = clog2_min1(CO);
    localparam int IDX_W  = clog2_min1(TOTAL);

    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(DEPTH - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(CO - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TOTAL - 1);

    state_e             state_q, state_d;
    logic [POS_W-1:0]   wcnt_q, wcnt_d;
    logic [IDX_W-1:0]   rcnt_q, rcnt_d;
    logic [POS_W-1:0]   rpos_q, rpos_d;
    logic [LANE_W-1:0]  rch_q, rch_d;
    logic               o_valid_q, o_valid_d;
    logic               o_last_q, o_last_d;
    logic               o_busy_q, o_busy_d;
    logic               o_err_q, o_err_d;
    logic               wr_en_s;
    logic               rd_en_s;

    // Next-state, counters and error flag
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        rpos_d    = rpos_q;
        rch_d     = rch_q;
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        o_err_d   = o_err_q;
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;

        case (state_q)
            IDLE, FILL: begin
                if (i_valid) begin
                    wr_en_s = 1'b1;
                    if (wcnt_q == POS_LAST) begin
                        state_d = DRAIN;
                        wcnt_d  = '0;
                        o_err_d = o_err_q | ~i_end;
                    end else begin
                        state_d = FILL;
                        wcnt_d  = wcnt_q + POS_W'(1);
                        o_err_d = o_err_q | i_end;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DRAIN: begin
                // Upstream is not stalled, so anything arriving now is lost
                o_err_d = o_err_q | i_valid;
                if (!o_valid_q) begin
                    rd_en_s = 1'b1;
                end else if (i_ready) begin
                    if (o_last_q) begin
                        state_d   = IDLE;
                        o_valid_d = 1'b0;
                        o_last_d  = 1'b0;
                        rcnt_d    = '0;
                        rpos_d    = '0;
                        rch_d     = '0;
                    end else begin
                        rd_en_s = 1'b1;
                    end
                end else begin
                    rd_en_s = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_en_s) begin
            o_valid_d = 1'b1;
            o_last_d  = (rcnt_q == IDX_LAST);
            rcnt_d    = rcnt_q + IDX_W'(1);
`ifdef POOLBUF_HWC_ORDER_EN
            if (rch_q == LANE_LAST) begin
                rch_d  = '0;
                rpos_d = rpos_q + POS_W'(1);
            end else begin
                rch_d  = rch_q + LANE_W'(1);
            end
`else
            if (rpos_q == POS_LAST) begin
                rpos_d = '0;
                rch_d  = rch_q + LANE_W'(1);
            end else begin
                rpos_d = rpos_q + POS_W'(1);
            end
`endif
        end else begin
            rcnt_d = rcnt_d;
        end

        o_busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            rpos_q    <= '0;
            rch_q     <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_busy_q  <= 1'b0;
            o_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            rpos_q    <= rpos_d;
            rch_q     <= rch_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_busy_q  <= o_busy_d;
            o_err_q   <= o_err_d;
        end
    end

    pool_buf_mem #(
        .CO    (CO),
        .BW    (BW),
        .DEPTH (DEPTH),
        .AW    (POS_W),
        .LW    (LANE_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wcnt_q),
        .wr_data_i (i_data),
        .rd_en_i   (rd_en_s),
        .rd_addr_i (rpos_q),
        .rd_lane_i (rch_q),
        .rd_data_o (o_data)
    );

    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_busy  = o_busy_q;
    assign o_err   = o_err_q;

endmodule

// File: tb/tb_pool_flatten_buf.sv
// Directed/randomised bench for pool_flatten_buf against a frame-level reference model.
module tb_pool_flatten_buf;

    localparam int CO    = 3;
    localparam int BW    = 32;
    localparam int FM    = 4;
    localparam int DEPTH = FM * FM;
    localparam int TOTAL = CO * DEPTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [CO*BW-1:0] i_data;
    logic             i_valid;
    logic             i_end;
    logic             i_ready;
    logic [BW-1:0]    o_data;
    logic             o_valid;
    logic             o_last;
    logic             o_busy;
    logic             o_err;

    int errors = 0;
    int checks = 0;
    bit exp_err;
    int vc;

    logic [BW-1:0] ref_m [DEPTH][CO];

    always #5 clk = ~clk;

    pool_flatten_buf #(.CO(CO), .BW(BW), .FM_SIZE(FM)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_end   (i_end),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .i_ready (i_ready),
        .o_busy  (o_busy),
        .o_err   (o_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value expected at flattened output index idx
    function automatic logic [BW-1:0] exp_at(input int idx);
`ifdef POOLBUF_HWC_ORDER_EN
        return ref_m[idx / CO][idx % CO];
`else
        return ref_m[idx % DEPTH][idx / DEPTH];
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; i_end = 1'b0; i_ready = 1'b0; i_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  o_data,  0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last",  o_last,  0);
        chk("rst_busy",  o_busy,  0);
        chk("rst_err",   o_err,   0);
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    // mode 0: c*100+p pattern, otherwise random values
    task automatic send_frame(input int mode, input logic [DEPTH-1:0] end_mask, input bit gaps);
        for (int p = 0; p < DEPTH; p++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                i_valid = 1'b0; i_end = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            for (int c = 0; c < CO; c++) begin
                logic [BW-1:0] v;
                v = (mode == 0) ? BW'(c * 100 + p) : BW'($urandom);
                ref_m[p][c] = v;
                i_data[c*BW +: BW] = v;
            end
            i_valid = 1'b1;
            i_end   = end_mask[p];
            if (p != DEPTH - 1 && end_mask[p]) exp_err = 1'b1;
            if (p == DEPTH - 1 && !end_mask[p]) exp_err = 1'b1;
            @(posedge clk); #1;
            if (p == 0) chk("busy_rise", o_busy, 1);
        end
        i_valid = 1'b0; i_end = 1'b0;
        chk("busy_fill", o_busy, 1);
    endtask

    // mode 0: ready high, 1: ready toggling starting low, 2: random ready
    task automatic drain(input int mode, input int stop_after, input int inj_at, output int vcyc);
        int k;
        int cyc;
        bit acc;
        k = 0; cyc = 0; vcyc = 0;
        chk("lat_pre", o_valid, 0);
        @(posedge clk); #1;
        chk("lat_first", o_valid, 1);
        while (k < stop_after && cyc < 2000) begin
            i_valid = 1'b0;
            chk("drain_valid", o_valid, 1);
            if (o_valid) begin
                chk("drain_data", o_data, exp_at(k));
                chk("drain_last", o_last, (k == TOTAL - 1));
                case (mode)
                    0:       i_ready = 1'b1;
                    1:       i_ready = (vcyc % 2 == 1);
                    default: i_ready = 1'($urandom_range(0, 1));
                endcase
                acc = i_ready;
                if (vcyc == inj_at) begin
                    i_valid = 1'b1;
                    i_data  = {CO{32'h0000_DEAD}};
                    exp_err = 1'b1;
                end
                vcyc++;
            end else begin
                acc = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) k++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        if (cyc >= 2000) chk("drain_timeout", 0, 1);
        if (stop_after == TOTAL) begin
            chk("post_valid", o_valid, 0);
            chk("post_busy",  o_busy,  0);
        end
    endtask

    initial begin
        do_reset();

        // nominal frame
        send_frame(0, 16'h8000, 1'b0);
        chk("nom_err_fill", o_err, exp_err);
        drain(0, TOTAL, -1, vc);
        chk("nom_cycles", vc, TOTAL);
        chk("nom_err", o_err, 0);

        // backpressure
        send_frame(0, 16'h8000, 1'b0);
        drain(1, TOTAL, -1, vc);
        chk("bp_cycles", vc, 2 * TOTAL);
        chk("bp_err", o_err, 0);

        // early end on beat 10, correct end also present
        send_frame(0, 16'h8200, 1'b0);
        chk("early_err", o_err, 1);
        drain(0, TOTAL, -1, vc);
        chk("early_err_sticky", o_err, exp_err);

        // beat during drain
        do_reset();
        send_frame(1, 16'h8000, 1'b1);
        chk("inj_err_pre", o_err, 0);
        drain(2, TOTAL, 7, vc);
        chk("inj_err", o_err, 1);

        // reset mid-drain, then a fresh frame
        send_frame(1, 16'h8000, 1'b0);
        drain(0, 20, -1, vc);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_busy",  o_busy,  0);
        chk("mid_rst_err",   o_err,   0);
        chk("mid_rst_last",  o_last,  0);
        rst = 1'b0;
        exp_err = 1'b0;
        send_frame(1, 16'h8000, 1'b0);
        drain(2, TOTAL, -1, vc);
        chk("fresh_err", o_err, 0);

        // missing end on final beat
        send_frame(1, 16'h0000, 1'b1);
        chk("noend_err", o_err, 1);
        drain(2, TOTAL, -1, vc);
        chk("noend_err_sticky", o_err, exp_err);

        // random frames
        do_reset();
        for (int f = 0; f < 3; f++) begin
            send_frame(1, 16'h8000, 1'b1);
            drain(2, TOTAL, -1, vc);
            chk("rand_err", o_err, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pool_flatten_buf.md
# pool_flatten_buf

Receiving end of the convolution-layer output stream: captures the CO-channel pooled feature map as it emerges (one CO-wide word per valid beat, frame closed by an end strobe), buffers the full frame, then replays it as a single-channel flattened stream to the fully-connected stage under a valid/ready handshake. It sits between the conv/ReLU/maxpool layer and the first dense layer.

## Interface
- CO, 3, number of channels per input beat
- BW, 32, signed bits per channel value
- FM_SIZE, 4, pooled map edge; DEPTH = FM_SIZE*FM_SIZE positions per channel
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_data  in  CO*BW  pooled values; channel c at [c*BW +: BW]
- i_valid  in  1  beat valid (no backpressure on this side)
- i_end  in  1  last beat of frame, qualified by i_valid
- o_data  out  BW  flattened output value
- o_valid  out  1  output beat valid
- o_last  out  1  final beat of flattened frame
- i_ready  in  1  downstream accepts when o_valid & i_ready
- o_busy  out  1  high in FILL or DRAIN
- o_err  out  1  sticky: frame-length mismatch or beat dropped

## Operation
- One clock, synchronous active-high reset.
- States: IDLE, FILL, DRAIN.
- IDLE: first i_valid writes position 0 and moves to FILL (wcnt=1). If DEPTH==1, go straight to DRAIN.
- FILL: each i_valid writes all CO channels at position wcnt; wcnt increments.
- Position DEPTH-1 written -> DRAIN.
- i_end on a beat other than position DEPTH-1 -> set o_err; i_end does not change state.
- Missing i_end on position DEPTH-1 -> set o_err; DRAIN is still entered.
- DRAIN: rcnt walks 0..CO*DEPTH-1, channel-major: index = ch*DEPTH + pos.
- Beat advances only when o_valid & i_ready.
- o_last high with o_valid on index CO*DEPTH-1.
- Acceptance of the last beat -> IDLE; o_valid drops next cycle.
- i_valid during DRAIN is dropped and sets o_err. Buffer contents are not modified.
- Data passes through unchanged, with no width change or arithmetic. Sign is preserved.
- Reset mid-frame: state IDLE; counters 0; o_valid, o_last, o_busy, o_err all 0. Buffer contents undefined.
- o_err clears only on rst.

## Timing
- Reset values: o_data 0, o_valid 0, o_last 0, o_busy 0, o_err 0.
- Write latency: the beat on cycle t is stored at the t+1 edge.
- First o_valid appears 1 cycle after the edge that writes position DEPTH-1. o_data for index 0 is valid in that same cycle.
- All outputs are registered.
- While o_valid & !i_ready: o_data and o_last are held stable.
- With i_ready held high, one beat per cycle. Full drain takes CO*DEPTH cycles.
- o_busy rises the cycle after the first i_valid in IDLE. It falls the cycle after the last beat is accepted.
- A new frame's i_valid arriving in the same cycle as the DRAIN->IDLE transition is dropped and sets o_err. Upstream must idle for at least 1 cycle between frames.

## Configuration
- POOLBUF_HWC_ORDER_EN defined: drain is position-major, index = pos*CO + ch (all channels of position 0, then position 1, ...).
- POOLBUF_HWC_ORDER_EN undefined: channel-major order as described in Operation.
- Only the read-address generator differs between the two; all timing is identical.

## Structure
- Shared package conv_pkg holds:
  - default CO, BW, FM_SIZE constants
  - derived DEPTH and CO*DEPTH
  - counter-width localparams via $clog2
  - state typedef {IDLE, FILL, DRAIN}
- One sub-module, pool_buf_mem: CO-lane register/LUTRAM array.
  - DEPTH x (CO*BW) write port, registered BW-wide read port with lane select.
  - FSM, counters and address generation stay in the top module.

## Test plan
- Nominal frame: CO=3, FM_SIZE=4; 16 beats with ch c at pos p = c*100+p, i_end on beat 16, i_ready=1 -> 48 beats 0..15,100..115,200..215; o_last on value 215; o_err=0.
- Backpressure: i_ready toggled 1/0 per cycle during DRAIN -> same 48 values in order, each held while stalled; drain takes 96 cycles.
- Early i_end on beat 10 -> o_err=1 sticky; capture continues to 16 beats; full 48-beat drain still produced.
- Beat during DRAIN: extra i_valid with data 0xDEAD -> o_err=1; drained values unchanged.
- Reset mid-DRAIN after 20 beats accepted -> next cycle o_valid=0, o_busy=0, o_err=0; a fresh 16-beat frame then drains correctly.
- POOLBUF_HWC_ORDER_EN build, same stimulus as the nominal frame -> output 0,100,200,1,101,201,...,15,115,215.
